vend_txn_ctrl: RTL

Transaction controller for the vending machine: accumulates inserted coins, checks item selections against a per-item price table, and closes each purchase. It sits directly upstream of the output handler and drives its `end_trans`, `sum_money`, `price` and `item_select` inputs. The output handler's decoder dispenses the item and its subtractor computes change. Cancels and inactivity timeouts return the full credit on a separate refund path and never assert `end_trans`.

---
 rtl/vend_txn_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: collects coin credit, checks selections
// against a price table, and closes each purchase or refunds the credit.
module vend_txn_ctrl #(
  parameter logic [7:0]  PRICE_1 = 8'd15,
  parameter logic [7:0]  PRICE_2 = 8'd20,
  parameter logic [7:0]  PRICE_3 = 8'd25,
  parameter logic [7:0]  PRICE_4 = 8'd30,
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  output logic       end_trans,
  output logic [7:0] sum_money,
  output logic [7:0] price,
  output logic [1:0] item_select,
  output logic       refund_valid,
  output logic [7:0] refund_amt,
  output logic       coin_reject,
  output logic       no_funds
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE, REFUND} state_t;

  state_t      state, state_d;
  logic [7:0]  credit, credit_d;
  logic [7:0]  price_q, price_d;
  logic [1:0]  item_q, item_d;
  logic [15:0] idle_cnt, idle_cnt_d;
  logic        end_trans_d, refund_valid_d, coin_reject_d, no_funds_d;
  logic [7:0]  refund_amt_d;

  logic [7:0]  coin_val, sel_price;
  logic [8:0]  coin_sum;
  logic        coin_fits;

  always_comb begin
    coin_val = 8'd1;
    case (coin_type)
      2'b00:   coin_val = 8'd1;
      2'b01:   coin_val = 8'd5;
      2'b10:   coin_val = 8'd10;
      default: coin_val = 8'd20;
    endcase
  end

  always_comb begin
    sel_price = PRICE_1;
    case (sel_item)
      2'b00:   sel_price = PRICE_1;
      2'b01:   sel_price = PRICE_2;
      2'b10:   sel_price = PRICE_3;
      default: sel_price = PRICE_4;
    endcase
  end

  // 9-bit sum: a carry into bit 8 means the coin would overflow the credit.
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_val};
  assign coin_fits = ~coin_sum[8];

  always_comb begin
    state_d        = state;
    credit_d       = credit;
    price_d        = '0;
    item_d         = '0;
    idle_cnt_d     = idle_cnt;
    end_trans_d    = 1'b0;
    refund_valid_d = 1'b0;
    refund_amt_d   = '0;
    coin_reject_d  = 1'b0;
    no_funds_d     = 1'b0;
    case (state)
      IDLE: begin
        idle_cnt_d = '0;
        no_funds_d = sel_valid;
        if (coin_valid) begin
          if (coin_fits) begin
            credit_d = coin_sum[7:0];
            state_d  = COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_d        = REFUND;
          refund_valid_d = 1'b1;
          refund_amt_d   = credit;
          idle_cnt_d     = '0;
          coin_reject_d  = coin_valid;
        end else if (sel_valid && (credit >= sel_price)) begin
          state_d       = DONE;
          end_trans_d   = 1'b1;
          price_d       = sel_price;
          item_d        = sel_item;
          idle_cnt_d    = '0;
          coin_reject_d = coin_valid;
        end else if (sel_valid || coin_valid) begin
          // A refused selection still lets a same-cycle coin through.
          no_funds_d = sel_valid;
          if (sel_valid) idle_cnt_d = '0;
          if (coin_valid) begin
            if (coin_fits) begin
              credit_d   = coin_sum[7:0];
              idle_cnt_d = '0;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end else if (idle_cnt == TIMEOUT - 16'd1) begin
          state_d        = REFUND;
          refund_valid_d = 1'b1;
          refund_amt_d   = credit;
          idle_cnt_d     = '0;
        end else begin
          idle_cnt_d = idle_cnt + 16'd1;
        end
      end
      DONE, REFUND: begin
        state_d       = IDLE;
        credit_d      = '0;
        idle_cnt_d    = '0;
        coin_reject_d = coin_valid;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      credit       <= '0;
      price_q      <= '0;
      item_q       <= '0;
      idle_cnt     <= '0;
      end_trans    <= 1'b0;
      refund_valid <= 1'b0;
      refund_amt   <= '0;
      coin_reject  <= 1'b0;
      no_funds     <= 1'b0;
    end else begin
      state        <= state_d;
      credit       <= credit_d;
      price_q      <= price_d;
      item_q       <= item_d;
      idle_cnt     <= idle_cnt_d;
      end_trans    <= end_trans_d;
      refund_valid <= refund_valid_d;
      refund_amt   <= refund_amt_d;
      coin_reject  <= coin_reject_d;
      no_funds     <= no_funds_d;
    end
  end

  assign sum_money   = credit;
  assign price       = price_q;
  assign item_select = item_q;

endmodule
